sequential_divider_taint: RTL

- Sequential restoring (shift-subtract) unsigned divider with gate-level-style information-flow taint tracking. It is the inverse-operation companion to the team's taint-tracked shift-add multiplier.
- Every data and control signal carries a parallel `_t` taint vector.
- Computes quotient and remainder of WIDTH-bit operands in WIDTH iteration cycles.
- Used in the same security-verification flow to check whether secret operands leak into timing or outputs.

---
 rtl/sequential_divider_taint.sv | 105 ++++++++++
 1 files changed

// File: rtl/sequential_divider_taint.sv
// sequential_divider_taint: restoring unsigned divider with taint tracking; DIVIDER_PRECISE_TAINT_EN selects per-iteration taint
module sequential_divider_taint #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] dividend_t,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0] divisor_t,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] quotient_t,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] remainder_t,
  output logic             quotientDone,
  output logic             quotientDone_t
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] r, q, dvs;
  logic [WIDTH:0] sh;
  logic ge, ctrl_taint;
  assign sh = {r, q[WIDTH-1]};
  assign ge = sh >= {1'b0, dvs};
`ifdef DIVIDER_PRECISE_TAINT_EN
  logic [WIDTH-1:0] r_t, q_t, dvs_t;
  logic [WIDTH:0] sh_t;
  logic cmp_t;
  assign sh_t = {r_t, q_t[WIDTH-1]};
  assign cmp_t = |sh_t | |dvs_t;
`else
  logic dt;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (start ? ITER : IDLE) :
              state == ITER ? (cnt == CW'(WIDTH - 1) ? DONE : ITER) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      r <= '0;
      q <= '0;
      dvs <= '0;
      ctrl_taint <= 1'b0;
      quotient <= '0;
      quotient_t <= '0;
      remainder <= '0;
      remainder_t <= '0;
      quotientDone <= 1'b0;
      quotientDone_t <= 1'b0;
`ifdef DIVIDER_PRECISE_TAINT_EN
      r_t <= '0;
      q_t <= '0;
      dvs_t <= '0;
`else
      dt <= 1'b0;
`endif
    end else begin
      if (state == IDLE) ctrl_taint <= start_t;
      quotientDone <= state == DONE;
      quotientDone_t <= state == DONE && ctrl_taint;
      if (state == IDLE && start) begin
        cnt <= '0;
        r <= '0;
        q <= dividend;
        dvs <= divisor;
`ifdef DIVIDER_PRECISE_TAINT_EN
        r_t <= '0;
        q_t <= dividend_t;
        dvs_t <= divisor_t;
`else
        dt <= |dividend_t | |divisor_t;
`endif
      end
      if (state == ITER) begin
        cnt <= cnt + 1'b1;
        r <= WIDTH'(ge ? sh - {1'b0, dvs} : sh);
        q <= {q[WIDTH-2:0], ge};
`ifdef DIVIDER_PRECISE_TAINT_EN
        q_t <= {q_t[WIDTH-2:0], cmp_t};
        r_t <= (cmp_t || (ge && |dvs_t)) ? '1 : sh_t[WIDTH-1:0];
`endif
      end
      if (state == DONE) begin
        quotient <= q;
        remainder <= r;
`ifdef DIVIDER_PRECISE_TAINT_EN
        quotient_t <= ctrl_taint ? '1 : q_t;
        remainder_t <= ctrl_taint ? '1 : r_t;
`else
        quotient_t <= {WIDTH{ctrl_taint | dt}};
        remainder_t <= {WIDTH{ctrl_taint | dt}};
`endif
      end
    end
  end
endmodule
